// File: rtl/noc_traffic_gen_pkg.sv
// noc_traffic_gen_pkg: shared pattern codes, payload field widths, FSM states and LFSR step
package noc_traffic_gen_pkg;

    localparam logic [1:0] TG_UNIFORM   = 2'd0;
    localparam logic [1:0] TG_TORNADO   = 2'd1;
    localparam logic [1:0] TG_BITCOMP   = 2'd2;
    localparam logic [1:0] TG_NEIGHBOUR = 2'd3;

    localparam int SEQ_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/noc_traffic_gen_lfsr16.sv
// noc_lfsr16: 16-bit Galois LFSR with reset seed and step enable
module noc_lfsr16
    import noc_traffic_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= SEED;
        else if (i_en)
            r_state <= lfsr16_next(r_state);
    end

    assign o_state = r_state;

endmodule

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: per-PE packet injector forming {dest, src, seq, ts} flits for the NoC PE port
module noc_traffic_gen
    import noc_traffic_gen_pkg::*;
#(
    parameter int          address      = 0,
    parameter int          numPE        = 8,
    parameter int          AddressWidth = $clog2(numPE),
    parameter int          DataWidth    = 32,
    parameter int          TotalWidth   = AddressWidth + DataWidth,
    parameter int          PktLimit     = 100,
    parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic [1:0]            i_pattern,
    input  logic [7:0]            i_inject_rate,
    output logic [TotalWidth-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [15:0]           o_sent_count,
    output logic                  o_done
);

    localparam int AW  = AddressWidth;
    localparam int TSW = DataWidth - AW - SEQ_W;

    localparam logic [AW-1:0] SRC      = AW'(address);
    localparam int            TORN_RAW = (address + (numPE + 1) / 2 - 1) % numPE;
    localparam logic [AW-1:0] DST_TORN = AW'((TORN_RAW == address) ? (address + 1) % numPE : TORN_RAW);
    localparam int            BC_RAW   = ~address & ((1 << AW) - 1);
    localparam logic [AW-1:0] DST_BC   = AW'((BC_RAW >= numPE) ? numPE - 1 - address : BC_RAW);
    localparam logic [AW-1:0] DST_NB   = AW'((address + 1) % numPE);

    logic [15:0]           w_lfsr;
    logic [7:0]            w_rb;
    logic [7:0]            w_rf;
    logic [AW-1:0]         w_dest;
    logic                  w_inj;
    logic                  w_hs;
    logic                  w_last;
    logic [15:0]           w_seq_ld;
    logic [TotalWidth-1:0] w_flit;

    logic [1:0]            r_state;
    logic [TotalWidth-1:0] r_data;
    logic [15:0]           r_cnt;
    logic [15:0]           r_seq;
    logic [TSW-1:0]        r_ts;

    noc_lfsr16 #(.SEED(LfsrSeed ^ 16'(address))) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    // The masked byte is below 2*numPE, so one conditional subtract folds it into range
    assign w_rb = w_lfsr[15:8] & 8'((1 << AW) - 1);
    assign w_rf = (w_rb >= 8'(numPE)) ? w_rb - 8'(numPE) : w_rb;

    always_comb
        w_dest = (i_pattern == TG_UNIFORM) ? ((w_rf == 8'(address)) ? DST_NB : w_rf[AW-1:0]) :
                 (i_pattern == TG_TORNADO) ? DST_TORN :
                 (i_pattern == TG_BITCOMP) ? DST_BC : DST_NB;

    assign w_inj    = i_enable & ((i_inject_rate == 8'hFF) | (w_lfsr[7:0] < i_inject_rate));
    assign w_hs     = (r_state == ST_SEND) & i_data_ready;
    assign w_last   = (r_cnt + 16'd1) == 16'(PktLimit);
    assign w_seq_ld = w_hs ? r_seq + 16'd1 : r_seq;
    assign w_flit   = {w_dest, SRC, w_seq_ld, r_ts};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_seq   <= '0;
            r_ts    <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (r_state == ST_IDLE && w_inj) begin
                r_data  <= w_flit;
                r_state <= ST_SEND;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 16'd1;
                r_seq <= r_seq + 16'd1;
                if (w_last)
                    r_state <= ST_DONE;
                else if (w_inj)
                    r_data <= w_flit;
                else
                    r_state <= ST_IDLE;
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_state == ST_SEND;
    assign o_sent_count = r_cnt;
    assign o_done       = r_state == ST_DONE;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb_noc_traffic_gen: directed scenario tasks over four injector instances at different node addresses
module tb_noc_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic [1:0]  i_pattern = 2'd0;
    logic [7:0]  i_inject_rate = 8'd0;
    logic        i_data_ready = 1'b0;

    logic [34:0] d2, d5, d7, d0;
    logic        v2, v5, v7, v0;
    logic        dn2, dn5, dn7, dn0;
    logic [15:0] c2, c5, c7, c0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    noc_traffic_gen #(.address(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pattern(i_pattern),
        .i_inject_rate(i_inject_rate), .o_data(d2), .o_data_valid(v2),
        .i_data_ready(i_data_ready), .o_sent_count(c2), .o_done(dn2)
    );

    noc_traffic_gen #(.address(5), .PktLimit(65535)) u_a5 (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pattern(i_pattern),
        .i_inject_rate(i_inject_rate), .o_data(d5), .o_data_valid(v5),
        .i_data_ready(i_data_ready), .o_sent_count(c5), .o_done(dn5)
    );

    noc_traffic_gen #(.address(7), .PktLimit(65535)) u_a7 (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pattern(i_pattern),
        .i_inject_rate(i_inject_rate), .o_data(d7), .o_data_valid(v7),
        .i_data_ready(i_data_ready), .o_sent_count(c7), .o_done(dn7)
    );

    noc_traffic_gen #(.address(0), .PktLimit(10000)) u_a0 (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pattern(i_pattern),
        .i_inject_rate(i_inject_rate), .o_data(d0), .o_data_valid(v0),
        .i_data_ready(i_data_ready), .o_sent_count(c0), .o_done(dn0)
    );

    function automatic logic [2:0] f_dest(input logic [34:0] d);
        return d[34:32];
    endfunction

    function automatic logic [2:0] f_src(input logic [34:0] d);
        return d[31:29];
    endfunction

    function automatic logic [15:0] f_seq(input logic [34:0] d);
        return d[28:13];
    endfunction

    function automatic logic [12:0] f_ts(input logic [34:0] d);
        return d[12:0];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_enable = 1'b1;
        i_inject_rate = 8'hFF;
        i_data_ready = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        total++; if (d2 !== 35'd0) begin bad++; $display("FAIL reset_data: got %h want 0", d2); end
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", v2); end
        total++; if (c2 !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", c2); end
        total++; if (dn2 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", dn2); end
        rst_n = 1'b1;
    endtask

    task automatic test_tornado();
        i_pattern = 2'd1;
        i_inject_rate = 8'hFF;
        i_data_ready = 1'b1;
        i_enable = 1'b1;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            total++; if (v2 !== 1'b1) begin bad++; $display("FAIL torn_valid[%0d]: got %b want 1", k, v2); end
            total++; if (f_dest(d2) !== 3'd5) begin bad++; $display("FAIL torn_dest[%0d]: got %0d want 5", k, f_dest(d2)); end
            total++; if (f_src(d2) !== 3'd2) begin bad++; $display("FAIL torn_src[%0d]: got %0d want 2", k, f_src(d2)); end
            total++; if (f_seq(d2) !== 16'(k)) begin bad++; $display("FAIL torn_seq[%0d]: got %0d want %0d", k, f_seq(d2), k); end
            total++; if (f_ts(d2) !== 13'(k)) begin bad++; $display("FAIL torn_ts[%0d]: got %0d want %0d", k, f_ts(d2), k); end
            total++; if (c2 !== 16'(k)) begin bad++; $display("FAIL torn_count[%0d]: got %0d want %0d", k, c2, k); end
        end
        @(negedge clk);
        total++; if (dn2 !== 1'b1) begin bad++; $display("FAIL torn_done: got %b want 1", dn2); end
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL torn_valid_after: got %b want 0", v2); end
        total++; if (c2 !== 16'd100) begin bad++; $display("FAIL torn_count_final: got %0d want 100", c2); end
        cyc(5);
        total++; if (dn2 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL torn_done_sticky: done=%b valid=%b want 1/0", dn2, v2); end
    endtask

    task automatic test_ready_toggle();
        logic [34:0] prev_d;
        logic        prev_hold;
        logic        rdy;
        int          exp_seq;
        i_pattern = 2'd1;
        i_inject_rate = 8'hFF;
        i_data_ready = 1'b0;
        i_enable = 1'b1;
        do_reset();
        exp_seq = 0;
        prev_hold = 1'b0;
        prev_d = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            rdy = (i % 4) == 0;
            if (v2) begin
                if (prev_hold) begin
                    total++; if (d2 !== prev_d) begin bad++; $display("FAIL hold_data[%0d]: got %h want %h", i, d2, prev_d); end
                end
                if (rdy) begin
                    total++; if (f_seq(d2) !== 16'(exp_seq)) begin bad++; $display("FAIL hold_seq[%0d]: got %0d want %0d", i, f_seq(d2), exp_seq); end
                    exp_seq++;
                end
            end
            prev_hold = v2 && !rdy;
            prev_d = d2;
            i_data_ready = rdy;
        end
        @(negedge clk);
        total++; if (c2 !== 16'(exp_seq)) begin bad++; $display("FAIL hold_count: got %0d want %0d", c2, exp_seq); end
        total++; if (exp_seq < 15) begin bad++; $display("FAIL hold_progress: got %0d handshakes want >=15", exp_seq); end
    endtask

    task automatic test_uniform();
        int hist [8];
        int n;
        foreach (hist[j]) hist[j] = 0;
        i_pattern = 2'd0;
        i_inject_rate = 8'hFF;
        i_data_ready = 1'b1;
        i_enable = 1'b1;
        do_reset();
        n = 0;
        while (n < 12000 && !dn0) begin
            @(negedge clk);
            if (v0) hist[f_dest(d0)]++;
            n++;
        end
        total++; if (dn0 !== 1'b1) begin bad++; $display("FAIL uni_done: got %b want 1 after %0d cycles", dn0, n); end
        total++; if (c0 !== 16'd10000) begin bad++; $display("FAIL uni_count: got %0d want 10000", c0); end
        total++; if (hist[0] !== 0) begin bad++; $display("FAIL uni_self: got %0d flits to self want 0", hist[0]); end
        // Raw value 0 collides with this node and is redirected to 1, so dest 1 carries two shares
        total++; if (hist[1] < 2125 || hist[1] > 2875) begin bad++; $display("FAIL uni_bin1: got %0d want 2125..2875", hist[1]); end
        for (int j = 2; j < 8; j++) begin
            total++; if (hist[j] < 1062 || hist[j] > 1438) begin bad++; $display("FAIL uni_bin%0d: got %0d want 1062..1438", j, hist[j]); end
        end
    endtask

    task automatic test_patterns();
        i_pattern = 2'd2;
        i_inject_rate = 8'hFF;
        i_data_ready = 1'b0;
        i_enable = 1'b1;
        do_reset();
        cyc(2);
        total++; if (v5 !== 1'b1) begin bad++; $display("FAIL bc_valid: got %b want 1", v5); end
        total++; if (f_dest(d5) !== 3'd2) begin bad++; $display("FAIL bc_dest_a5: got %0d want 2", f_dest(d5)); end
        total++; if (f_src(d5) !== 3'd5) begin bad++; $display("FAIL bc_src_a5: got %0d want 5", f_src(d5)); end
        total++; if (f_dest(d2) !== 3'd5) begin bad++; $display("FAIL bc_dest_a2: got %0d want 5", f_dest(d2)); end
        i_pattern = 2'd3;
        do_reset();
        cyc(2);
        total++; if (f_dest(d7) !== 3'd0) begin bad++; $display("FAIL nb_dest_a7: got %0d want 0", f_dest(d7)); end
        total++; if (f_dest(d2) !== 3'd3) begin bad++; $display("FAIL nb_dest_a2: got %0d want 3", f_dest(d2)); end
        i_pattern = 2'd1;
        i_inject_rate = 8'h00;
        cyc(3);
        total++; if (f_dest(d2) !== 3'd3 || v2 !== 1'b1) begin bad++; $display("FAIL pend_stable: dest=%0d valid=%b want 3/1", f_dest(d2), v2); end
    endtask

    task automatic test_rate();
        int seen;
        i_pattern = 2'd3;
        i_inject_rate = 8'h00;
        i_data_ready = 1'b1;
        i_enable = 1'b1;
        do_reset();
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (v5) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rate0_valid: got %0d valid cycles want 0", seen); end
        total++; if (c5 !== 16'd0) begin bad++; $display("FAIL rate0_count: got %0d want 0", c5); end
        i_inject_rate = 8'h40;
        do_reset();
        cyc(4000);
        total++; if (c5 < 16'd880 || c5 > 16'd1120) begin bad++; $display("FAIL rate40_count: got %0d want 880..1120", c5); end
    endtask

    task automatic test_async_reset();
        logic [34:0] saved;
        i_pattern = 2'd1;
        i_inject_rate = 8'hFF;
        i_data_ready = 1'b1;
        i_enable = 1'b1;
        do_reset();
        cyc(3);
        i_data_ready = 1'b0;
        cyc(2);
        total++; if (v2 !== 1'b1 || c2 !== 16'd2) begin bad++; $display("FAIL pre_rst: valid=%b count=%0d want 1/2", v2, c2); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", v2); end
        total++; if (c2 !== 16'd0) begin bad++; $display("FAIL arst_count: got %0d want 0", c2); end
        total++; if (d2 !== 35'd0) begin bad++; $display("FAIL arst_data: got %h want 0", d2); end
        @(negedge clk);
        rst_n = 1'b1;
        i_data_ready = 1'b1;
        @(negedge clk);
        total++; if (v2 !== 1'b1 || f_seq(d2) !== 16'd0) begin bad++; $display("FAIL post_rst_seq: valid=%b seq=%0d want 1/0", v2, f_seq(d2)); end
        total++; if (f_ts(d2) >= 13'd4) begin bad++; $display("FAIL post_rst_ts: got %0d want <4", f_ts(d2)); end
        i_data_ready = 1'b0;
        @(negedge clk);
        i_enable = 1'b0;
        saved = d2;
        cyc(3);
        total++; if (v2 !== 1'b1 || d2 !== saved) begin bad++; $display("FAIL drain_hold: valid=%b data=%h want 1/%h", v2, d2, saved); end
        i_data_ready = 1'b1;
        @(negedge clk);
        total++; if (v2 !== 1'b0 || c2 !== 16'd1) begin bad++; $display("FAIL drain_done: valid=%b count=%0d want 0/1", v2, c2); end
        cyc(3);
        total++; if (v2 !== 1'b0 || c2 !== 16'd1) begin bad++; $display("FAIL drain_idle: valid=%b count=%0d want 0/1", v2, c2); end
    endtask

    initial begin
        test_reset();
        test_tornado();
        test_ready_toggle();
        test_patterns();
        test_rate();
        test_async_reset();
        test_uniform();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
